mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: the maximum number of ACCESS cycles to wait for mem_ready before aborting.
REQ-002 SHALL have ports: clock  input  1  system clock, rising edge.
REQ-003 SHALL have ports: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: p0_req / p1_req  input  1 each  access request from the CPU (p0) and the loader/debug port (p1).
REQ-005 SHALL have ports: p0_we / p1_we  input  1 each  write enable (1 = write, 0 = read).
REQ-006 SHALL have ports: p0_addr / p1_addr  input  32 each  word address.
REQ-007 SHALL have ports: p0_wdata / p1_wdata  input  32 each  write data.
REQ-008 SHALL have ports: p0_ack / p1_ack  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports: p0_err / p1_err  output  1 each  timeout flag, valid only with ack.
REQ-010 SHALL have ports: p0_rdata / p1_rdata  output  32 each  read data, held until that port's next read completes.
REQ-011 SHALL have ports: mem_req  output  1  memory access strobe.
REQ-012 SHALL have ports: mem_we  output  1  memory write enable.
REQ-013 SHALL have ports: mem_addr / mem_wdata  output  32 each  memory address and write data.
REQ-014 SHALL have ports: mem_ready  input  1  memory completion.
REQ-015 SHALL have ports: mem_rdata  input  32  memory read data.
REQ-016 SHALL have ports: busy  output  1  high in ACCESS.
REQ-017 SHALL have ports: gnt_id  output  1  port currently or last granted.

Function
REQ-018 SHALL implement FSM states IDLE and ACCESS, with transitions IDLE->ACCESS on any req and ACCESS->IDLE on mem_ready or timeout.
REQ-019 SHALL, in IDLE with a single requester, grant that requester.
REQ-020 SHALL, in IDLE with both requesting, grant the port not equal to last_gnt (round-robin).
REQ-021 SHALL, on a grant, register we/addr/wdata from the granted port, set gnt_id, and update last_gnt, all at the same edge.
REQ-022 SHALL drive mem_req=1 and mem_we/mem_addr/mem_wdata from the registered values throughout ACCESS, and keep them stable until exit.
REQ-023 SHALL, when a req is sampled at edge N, assert mem_req in the cycle after N.
REQ-024 SHALL, when mem_ready is sampled high at edge M: leave ACCESS at M, pulse the granted port's ack for exactly the cycle after M, and drive err=0 with that ack.
REQ-025 SHALL, for a read, load the granted port's rdata from mem_rdata at edge M; a write leaves rdata unchanged.
REQ-026 SHALL count ACCESS cycles with a saturating counter of width $clog2(TIMEOUT+1).
REQ-027 SHALL, if the count reaches TIMEOUT without mem_ready: deassert mem_req, pulse ack with err=1, return to IDLE, and leave rdata unchanged.
REQ-028 SHALL treat mem_ready arriving in the same cycle the timeout is reached as success.
REQ-029 SHALL ignore req deassertion during ACCESS: the access still completes and ack still pulses.
REQ-030 SHALL treat req still high after ack as a new request, arbitrated in IDLE in the following cycle.
REQ-031 SHALL ignore mem_ready while in IDLE.
REQ-032 SHALL never assert p0_ack and p1_ack in the same cycle.
REQ-033 SHALL allow a new grant no sooner than two cycles after the previous mem_ready.

Reset
REQ-034 SHALL, while reset_n is low: state=IDLE; counter=0; last_gnt=1 (p0 wins the first tie); gnt_id=0; all ack, err and mem_* outputs 0; busy=0; both rdata registers 0.
REQ-035 SHALL, on reset mid-ACCESS, drop mem_req asynchronously and issue no ack.

Structure
REQ-036 SHALL place the state enum, TIMEOUT default and port-index constants (P_CPU=0, P_LDR=1) in shared package mem_arb_pkg.
REQ-037 SHALL implement the tie-break as combinational sub-module mem_arb_rr (inputs req[1:0] and last_gnt; output pick).

Verification
REQ-038 SHALL cover: p0 read addr 0x40, mem_ready 3 cycles later with mem_rdata 0x12345678 -> p0_ack one cycle, p0_rdata=0x12345678, p1 signals idle.
REQ-039 SHALL cover: p0 and p1 both req from reset, both held -> grants p0,p1,p0,p1, with gnt_id and acks alternating.
REQ-040 SHALL cover: p1 write addr 0x10 data 0xCAFEF00D -> mem_we=1, mem_addr=0x10, mem_wdata=0xCAFEF00D stable until mem_ready, p1_rdata unchanged.
REQ-041 SHALL cover: mem_ready never asserted, TIMEOUT=15 -> mem_req high 15 cycles, then p0_ack with p0_err=1, FSM back in IDLE.
REQ-042 SHALL cover: reset_n pulled low 2 cycles into ACCESS -> mem_req 0 immediately, no ack; after release, the first tie goes to p0.
REQ-043 SHALL cover: p0_req dropped 1 cycle after grant -> access completes and p0_ack still pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEF = 15;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       pick
);

  always_comb begin
    pick = P_CPU;
    if (req == 2'b11) begin
      pick = ~last_gnt;
    end else if (req[P_LDR]) begin
      pick = P_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a loader/debug port onto a single memory
// interface, with a per-access timeout and registered completion pulses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p0_err,
  output logic        p1_err,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        gnt_id
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_id_q, gnt_id_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic             pick;

  mem_arb_rr u_rr (
    .req      ({p1_req, p0_req}),
    .last_gnt (last_gnt_q),
    .pick     (pick)
  );

  assign cnt_inc = (cnt_q == TO_CNT) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = '0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d    = ACCESS;
          cnt_d      = '0;
          gnt_id_d   = pick;
          last_gnt_d = pick;
          we_d       = (pick == P_LDR) ? p1_we    : p0_we;
          addr_d     = (pick == P_LDR) ? p1_addr  : p0_addr;
          wdata_d    = (pick == P_LDR) ? p1_wdata : p0_wdata;
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        // mem_ready takes priority, so a completion on the timeout cycle is a success
        if (mem_ready) begin
          state_d         = IDLE;
          cnt_d           = '0;
          ack_d[gnt_id_q] = 1'b1;
          if (!we_q) begin
            rdata_d[gnt_id_q] = mem_rdata;
          end
        end else if (cnt_inc == TO_CNT) begin
          state_d         = IDLE;
          cnt_d           = '0;
          ack_d[gnt_id_q] = 1'b1;
          err_d           = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= P_LDR;
      gnt_id_q   <= P_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory-side outputs derive from state so an asynchronous reset clears them at once.
  assign busy      = (state_q == ACCESS);
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign p0_ack   = ack_q[P_CPU];
  assign p1_ack   = ack_q[P_LDR];
  assign p0_err   = ack_q[P_CPU] & err_q;
  assign p1_err   = ack_q[P_LDR] & err_q;
  assign p0_rdata = rdata_q[P_CPU];
  assign p1_rdata = rdata_q[P_LDR];
  assign gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int TMO = 15;
  localparam logic [31:0] A0 = 32'h0000_0040;
  localparam logic [31:0] A1 = 32'h0000_0010;
  localparam logic [31:0] W0 = 32'h5555_AAAA;
  localparam logic [31:0] W1 = 32'hCAFE_F00D;

  logic        clock;
  logic        reset_n;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_req, mem_we, mem_ready, busy, gnt_id;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .p0_req    (p0_req),
    .p1_req    (p1_req),
    .p0_we     (p0_we),
    .p1_we     (p1_we),
    .p0_addr   (p0_addr),
    .p1_addr   (p1_addr),
    .p0_wdata  (p0_wdata),
    .p1_wdata  (p1_wdata),
    .p0_ack    (p0_ack),
    .p1_ack    (p1_ack),
    .p0_err    (p0_err),
    .p1_err    (p1_err),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .gnt_id    (gnt_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic        rdy;
    logic [31:0] rd;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [1:0]  e_ack;
    logic        e_gnt;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we, input logic rdy,
                              input logic [31:0] rd, input logic e_mreq, input logic e_mwe,
                              input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                              input logic [1:0] e_ack, input logic e_gnt,
                              input logic [31:0] e_rd0, input logic [31:0] e_rd1);
    vec_t r;
    r.req = req; r.we = we; r.rdy = rdy; r.rd = rd;
    r.e_mreq = e_mreq; r.e_mwe = e_mwe; r.e_maddr = e_maddr; r.e_mwdata = e_mwdata;
    r.e_ack = e_ack; r.e_gnt = e_gnt; r.e_rd0 = e_rd0; r.e_rd1 = e_rd1;
    return r;
  endfunction

  // Transaction-level reference: who owns the memory, for how many cycles so far.
  logic        m_acc;
  int          m_cnt;
  logic        m_owner, m_last, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_ack;
  logic        m_err;
  logic [31:0] m_rd [2];

  task automatic model_reset();
    m_acc = 1'b0; m_cnt = 0; m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_ack = '0; m_err = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  task automatic model_edge(input logic r0, input logic r1, input logic w0, input logic w1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic rdy, input logic [31:0] rd);
    m_ack = '0;
    m_err = 1'b0;
    if (m_acc) begin
      m_cnt++;
      if (rdy || m_cnt >= TMO) begin
        m_acc = 1'b0;
        m_ack[m_owner] = 1'b1;
        m_err = !rdy;
        if (rdy && !m_we) m_rd[m_owner] = rd;
      end
    end else if (r0 || r1) begin
      m_owner = (r0 && r1) ? ~m_last : r1;
      m_last  = m_owner;
      m_acc   = 1'b1;
      m_cnt   = 0;
      m_we    = m_owner ? w1 : w0;
      m_addr  = m_owner ? a1 : a0;
      m_wdata = m_owner ? d1 : d0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b1;
    p0_addr = A0; p1_addr = A1; p0_wdata = W0; p1_wdata = W1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) step();
    chk("rst_ctrl", 128'({mem_req, mem_we, busy, gnt_id, p0_ack, p1_ack, p0_err, p1_err}), 128'(0));
    chk("rst_mem", 128'({mem_addr, mem_wdata}), 128'(0));
    chk("rst_rdata", 128'({p0_rdata, p1_rdata}), 128'(0));
    p1_we = 1'b0;
    reset_n = 1'b1;

    // both held from reset with mem_ready high: p0,p1,p0,p1
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB00,       1, 0, A0, W0, 2'b00, 0, 32'h0,   32'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB01,       0, 0, 0,  0,  2'b01, 0, 32'hB01, 32'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB02,       1, 0, A1, W1, 2'b00, 1, 32'hB01, 32'h0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB03,       0, 0, 0,  0,  2'b10, 1, 32'hB01, 32'hB03));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB04,       1, 0, A0, W0, 2'b00, 0, 32'hB01, 32'hB03));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB05,       0, 0, 0,  0,  2'b01, 0, 32'hB05, 32'hB03));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB06,       1, 0, A1, W1, 2'b00, 1, 32'hB05, 32'hB03));
    tbl.push_back(mk(2'b11, 2'b00, 1'b1, 32'hB07,       0, 0, 0,  0,  2'b10, 1, 32'hB05, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         0, 0, 0,  0,  2'b00, 1, 32'hB05, 32'hB07));
    // p0 read of 0x40, request dropped after grant, ready on third access cycle
    tbl.push_back(mk(2'b01, 2'b00, 1'b0, 32'h0,         1, 0, A0, W0, 2'b00, 0, 32'hB05, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         1, 0, A0, W0, 2'b00, 0, 32'hB05, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         1, 0, A0, W0, 2'b00, 0, 32'hB05, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b1, 32'h1234_5678, 0, 0, 0,  0,  2'b01, 0, 32'h1234_5678, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         0, 0, 0,  0,  2'b00, 0, 32'h1234_5678, 32'hB07));
    // p1 write of 0xCAFEF00D to 0x10
    tbl.push_back(mk(2'b10, 2'b10, 1'b0, 32'h0,         1, 1, A1, W1, 2'b00, 1, 32'h1234_5678, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         1, 1, A1, W1, 2'b00, 1, 32'h1234_5678, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         1, 1, A1, W1, 2'b00, 1, 32'h1234_5678, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b1, 32'hDEAD_BEEF, 0, 0, 0,  0,  2'b10, 1, 32'h1234_5678, 32'hB07));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 32'h0,         0, 0, 0,  0,  2'b00, 1, 32'h1234_5678, 32'hB07));

    for (int i = 0; i < tbl.size(); i++) begin
      p0_req = tbl[i].req[0]; p1_req = tbl[i].req[1];
      p0_we = tbl[i].we[0];   p1_we = tbl[i].we[1];
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rd;
      step();
      chk($sformatf("vec%0d_ctrl", i),
          128'({mem_req, busy, gnt_id, p1_ack, p0_ack, p1_err, p0_err}),
          128'({tbl[i].e_mreq, tbl[i].e_mreq, tbl[i].e_gnt, tbl[i].e_ack, 2'b00}));
      if (tbl[i].e_mreq)
        chk($sformatf("vec%0d_mem", i), 128'({mem_we, mem_addr, mem_wdata}),
            128'({tbl[i].e_mwe, tbl[i].e_maddr, tbl[i].e_mwdata}));
      chk($sformatf("vec%0d_rdata", i), 128'({p1_rdata, p0_rdata}),
          128'({tbl[i].e_rd1, tbl[i].e_rd0}));
    end

    // timeout: mem_ready never comes
    p0_req = 1'b1; p0_we = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    step();
    chk("to_grant", 128'({mem_req, gnt_id}), 128'(2'b10));
    p0_req = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("to_len", 128'(n), 128'(TMO));
    chk("to_ack", 128'({p0_ack, p0_err, p1_ack, p1_err, busy}), 128'(5'b11000));
    chk("to_rdata", 128'(p0_rdata), 128'(32'h1234_5678));
    step();
    chk("to_ack_pulse", 128'({p0_ack, p0_err, busy}), 128'(3'b000));

    // mem_ready on the very cycle the timeout is reached counts as success
    p0_req = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    step();
    p0_req = 1'b0;
    repeat (TMO - 1) step();
    chk("tie_still_busy", 128'(mem_req), 128'(1));
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("tie_ack", 128'({p0_ack, p0_err, busy}), 128'(3'b100));
    chk("tie_rdata", 128'(p0_rdata), 128'(32'h0F0F_0F0F));
    step();

    // reset two cycles into an access
    p1_req = 1'b1; p1_we = 1'b1;
    step();
    p1_req = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_async_mreq", 128'({mem_req, busy, mem_we}), 128'(0));
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("rst_noack%0d", k), 128'({p0_ack, p1_ack, p0_err, p1_err}), 128'(0));
    end
    chk("rst_rdata_clr", 128'({p0_rdata, p1_rdata}), 128'(0));
    p0_req = 1'b1; p1_req = 1'b1; p1_we = 1'b0;
    reset_n = 1'b1;
    step();
    chk("rst_first_tie", 128'({mem_req, gnt_id, mem_addr}), 128'({2'b10, A0}));
    p0_req = 1'b0; p1_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rst_first_ack", 128'({p0_ack, p1_ack}), 128'(2'b10));

    // randomized traffic against the model
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p0_req = $urandom_range(0, 1) == 1;
      p1_req = $urandom_range(0, 1) == 1;
      p0_we = $urandom_range(0, 1) == 1;
      p1_we = $urandom_range(0, 1) == 1;
      p0_addr = $urandom; p1_addr = $urandom;
      p0_wdata = $urandom; p1_wdata = $urandom;
      mem_ready = (cyc % 300 < 60) ? 1'b0 : ($urandom_range(0, 4) == 0);
      mem_rdata = $urandom;
      step();
      model_edge(p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
                 mem_ready, mem_rdata);
      chk($sformatf("rnd%0d_ctrl", cyc),
          128'({mem_req, busy, gnt_id, p1_ack, p0_ack, p1_err, p0_err}),
          128'({m_acc, m_acc, m_owner, m_ack, m_err & m_ack[1], m_err & m_ack[0]}));
      if (m_acc)
        chk($sformatf("rnd%0d_mem", cyc), 128'({mem_we, mem_addr, mem_wdata}),
            128'({m_we, m_addr, m_wdata}));
      chk($sformatf("rnd%0d_rdata", cyc), 128'({p1_rdata, p0_rdata}), 128'({m_rd[1], m_rd[0]}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
